// File: rtl/mux_pkg.sv
// mux_pkg
//   Shared helpers for the pipelined word-select tree and future wide-select
//   blocks.
//   - MAX_SEL_W    : widest select the tree supports (N up to 256)
//   - stage_meta_t : per-stage sideband carried next to the reduced words
//                    (select bits still to be consumed + out-of-range flag)
//   - levels_for() : number of radix-4 tree levels for a given select width
//   - lanes_at()   : number of words present at the input of a given level
package mux_pkg;

  localparam int MAX_SEL_W = 8;

  // The data part of a stage payload is WIDTH-dependent, so each stage keeps
  // its words in its own vector and only the sideband lives in this struct.
  typedef struct packed {
    logic [MAX_SEL_W-1:0] sel_rem;
    logic                 err;
  } stage_meta_t;

  // Each level eats two select bits; an odd width leaves a final 1-bit level.
  function automatic int levels_for(input int sel_w);
    return (sel_w + 1) / 2;
  endfunction

  // Every level divides the word count by four (rounding up). The last
  // radix-2 level still lands on one word because 4**LEVELS >= N.
  function automatic int lanes_at(input int level, input int n);
    int lanes;
    lanes = n;
    for (int i = 0; i < level; i++) begin
      lanes = (lanes + 3) / 4;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/mux_level.sv
// mux_level
//   One level of the select tree: reduces groups of RADIX words to one word
//   using the low select bits, then registers the result together with the
//   remaining select bits, the out-of-range flag and a valid bit.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     up_words/sel/err    payload from the previous level (or the block input)
//     up_valid, up_ready  upstream handshake; up_ready = this stage can load
//     dn_words/sel/err    registered payload towards the next level
//     dn_valid, dn_ready  downstream handshake
module mux_level
  import mux_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int IN_WORDS = 4,
  parameter int RADIX    = 4,
  localparam int OUT_WORDS = (IN_WORDS + RADIX - 1) / RADIX,
  localparam int BITS      = (RADIX == 4) ? 2 : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_WORDS*WIDTH-1:0]  up_words,
  input  logic [MAX_SEL_W-1:0]       up_sel,
  input  logic                       up_err,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic [OUT_WORDS*WIDTH-1:0] dn_words,
  output logic [MAX_SEL_W-1:0]       dn_sel,
  output logic                       dn_err,
  output logic                       dn_valid,
  input  logic                       dn_ready
);

  logic [OUT_WORDS*RADIX*WIDTH-1:0] padded;
  logic [OUT_WORDS*WIDTH-1:0]       reduced;
  logic [BITS-1:0]                  pick;
  logic [OUT_WORDS*WIDTH-1:0]       data_q;
  stage_meta_t                      meta_q;
  logic                             valid_q;

  assign pick = up_sel[BITS-1:0];

  // An empty stage always loads, so bubbles collapse; a full stage loads
  // only when its own content moves on in the same cycle.
  assign up_ready = !valid_q || dn_ready;

  // Leaves beyond IN_WORDS read as zero so a partial last group selects 0.
  always_comb begin
    padded = '0;
    padded[IN_WORDS*WIDTH-1:0] = up_words;
  end

  // Behavioural group-of-RADIX select; an out-of-range request is forced to
  // zero here too so the zero result never depends on leaf padding.
  always_comb begin
    reduced = '0;
    for (int g = 0; g < OUT_WORDS; g++) begin
      for (int j = 0; j < RADIX; j++) begin
        if (pick == BITS'(j)) begin
          reduced[g*WIDTH +: WIDTH] = padded[(g*RADIX + j)*WIDTH +: WIDTH];
        end
      end
    end
    if (up_err) begin
      reduced = '0;
    end
  end

  // Payload only loads on a real transfer, so whatever sits on the upstream
  // bus while it is not valid never reaches the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      meta_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q         <= reduced;
        meta_q.sel_rem <= up_sel >> BITS;
        meta_q.err     <= up_err;
      end
    end
  end

  assign dn_words = data_q;
  assign dn_sel   = meta_q.sel_rem;
  assign dn_err   = meta_q.err;
  assign dn_valid = valid_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe
//   Pipelined N-to-1 word multiplexer built as a chain of radix-4 levels
//   (the final level is radix-2 when the select width is odd), one register
//   stage per level, valid/ready handshake with bubble collapsing.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     in_data             N packed words, word i = in_data[i*WIDTH +: WIDTH]
//     in_sel              index of the word to select
//     in_valid, in_ready  input handshake (in_ready is combinational)
//     out_data, out_err   selected word; out_err set when in_sel >= N
//     out_valid, out_ready output handshake
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int N      = 32,
  parameter int SEL_W  = $clog2(N),
  parameter int LEVELS = levels_for(SEL_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [MAX_SEL_W-1:0] sel_ext;
  logic                 sel_err;
  logic                 unused_sel;

  // Range check happens once, at capture into the first stage; the flag then
  // travels with the word through the rest of the tree.
  assign sel_ext = MAX_SEL_W'(in_sel);
  assign sel_err = (int'(in_sel) >= N);

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int IN_LANES  = lanes_at(k, N);
    localparam int OUT_LANES = lanes_at(k + 1, N);
    localparam int RADIX     = ((k == LEVELS - 1) && (SEL_W % 2 == 1)) ? 2 : 4;

    logic [IN_LANES*WIDTH-1:0]  up_words;
    logic [MAX_SEL_W-1:0]       up_sel;
    logic                       up_err;
    logic                       up_valid;
    logic                       up_ready;
    logic [OUT_LANES*WIDTH-1:0] dn_words;
    logic [MAX_SEL_W-1:0]       dn_sel;
    logic                       dn_err;
    logic                       dn_valid;
    logic                       dn_ready;

    if (k == 0) begin : g_head
      assign up_words = in_data;
      assign up_sel   = sel_ext;
      assign up_err   = sel_err;
      assign up_valid = in_valid;
      assign in_ready = up_ready;
    end else begin : g_link
      assign up_words = g_level[k-1].dn_words;
      assign up_sel   = g_level[k-1].dn_sel;
      assign up_err   = g_level[k-1].dn_err;
      assign up_valid = g_level[k-1].dn_valid;
    end

    // Ready ripples back combinationally from out_ready through the chain.
    if (k == LEVELS - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_level[k+1].up_ready;
    end

    mux_level #(
      .WIDTH    (WIDTH),
      .IN_WORDS (IN_LANES),
      .RADIX    (RADIX)
    ) u_level (
      .clk      (clk),
      .reset    (reset),
      .up_words (up_words),
      .up_sel   (up_sel),
      .up_err   (up_err),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .dn_words (dn_words),
      .dn_sel   (dn_sel),
      .dn_err   (dn_err),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready)
    );
  end

  assign out_data  = g_level[LEVELS-1].dn_words;
  assign out_err   = g_level[LEVELS-1].dn_err;
  assign out_valid = g_level[LEVELS-1].dn_valid;

  // Every select bit has been consumed by the last level.
  assign unused_sel = ^g_level[LEVELS-1].dn_sel;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe
//   Four instances: N=32 (main), N=5 (range check), N=2 and N=16 (random
//   handshake). A scoreboard per instance holds expected {err, word} values
//   computed from the word-i-is-base-or-i stimulus.
module tb_mux_tree_pipe;

  localparam int W = 64;

  typedef struct {
    int           sel;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic [32*W-1:0] data0;
  logic [5*W-1:0]  data1;
  logic [2*W-1:0]  data2;
  logic [16*W-1:0] data3;
  logic [4:0]      sel0;
  logic [2:0]      sel1;
  logic [0:0]      sel2;
  logic [3:0]      sel3;

  logic         vld   [4];
  logic         rdy   [4];
  logic [W-1:0] odata [4];
  logic         oerr  [4];
  logic         ovld  [4];
  logic         ordy  [4];

  logic [W:0] q0[$];
  logic [W:0] q1[$];
  logic [W:0] q2[$];
  logic [W:0] q3[$];

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           fires [4];
  int           pops  [4];
  int           last_pop_cyc [4];
  logic         held_valid [4];
  logic [W-1:0] held_data [4];
  logic         held_err [4];
  logic [W-1:0] last_data [4];
  logic         last_err [4];
  vec_t         tbl [8];

  always #5 clk = ~clk;

  mux_tree_pipe #(.WIDTH(W), .N(32)) dut0 (
    .clk(clk), .reset(reset), .in_data(data0), .in_sel(sel0),
    .in_valid(vld[0]), .in_ready(rdy[0]), .out_data(odata[0]),
    .out_err(oerr[0]), .out_valid(ovld[0]), .out_ready(ordy[0]));

  mux_tree_pipe #(.WIDTH(W), .N(5)) dut1 (
    .clk(clk), .reset(reset), .in_data(data1), .in_sel(sel1),
    .in_valid(vld[1]), .in_ready(rdy[1]), .out_data(odata[1]),
    .out_err(oerr[1]), .out_valid(ovld[1]), .out_ready(ordy[1]));

  mux_tree_pipe #(.WIDTH(W), .N(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(data2), .in_sel(sel2),
    .in_valid(vld[2]), .in_ready(rdy[2]), .out_data(odata[2]),
    .out_err(oerr[2]), .out_valid(ovld[2]), .out_ready(ordy[2]));

  mux_tree_pipe #(.WIDTH(W), .N(16)) dut3 (
    .clk(clk), .reset(reset), .in_data(data3), .in_sel(sel3),
    .in_valid(vld[3]), .in_ready(rdy[3]), .out_data(odata[3]),
    .out_err(oerr[3]), .out_valid(ovld[3]), .out_ready(ordy[3]));

  function automatic int nval(input int d);
    case (d)
      0: return 32;
      1: return 5;
      2: return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int selmask(input int d);
    case (d)
      0: return 31;
      1: return 7;
      2: return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [W-1:0] base(input int d);
    case (d)
      0: return 64'hA5A5_0000_0000_0000;
      1: return 64'h5A00_0000_0000_0000;
      2: return 64'h0123_4567_0000_0000;
      default: return 64'h0F0F_0000_0000_0000;
    endcase
  endfunction

  // Reference model: word i is base|i, anything at or beyond N is {err, 0}.
  function automatic logic [W:0] expect_of(input int d, input int s);
    if (s >= nval(d)) return {1'b1, {W{1'b0}}};
    return {1'b0, base(d) | W'(s)};
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic void qpush(input int d, input logic [W:0] e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic logic [W:0] qpop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %s, expected %s", name, got, want);
  endtask

  task automatic drive(input int d, input logic v, input int s, input logic r);
    vld[d]  = v;
    ordy[d] = r;
    case (d)
      0: sel0 = 5'(s);
      1: sel1 = 3'(s);
      2: sel2 = 1'(s);
      default: sel3 = 4'(s);
    endcase
  endtask

  // One clock of one instance: drive, settle, score the transfers that the
  // coming edge will perform, then advance to #1 after that edge.
  task automatic applyStimulus(input int d, input logic v, input int sel, input logic r);
    logic       fire;
    logic       pop;
    int         s;
    s = sel & selmask(d);
    drive(d, v, s, r);
    #1;
    fire = v && rdy[d];
    pop  = ovld[d] && r;
    if (held_valid[d])
      check("stall_hold", {oerr[d], odata[d]}, {held_err[d], held_data[d]});
    if (pop) begin
      if (qsize(d) == 0) fail("spurious_out", "out_valid=1", "no pending item");
      else check("out_word", {oerr[d], odata[d]}, qpop(d));
      pops[d]++;
      last_data[d]    = odata[d];
      last_err[d]     = oerr[d];
      last_pop_cyc[d] = cyc;
    end
    held_valid[d] = ovld[d] && !r;
    held_data[d]  = odata[d];
    held_err[d]   = oerr[d];
    if (fire) begin
      qpush(d, expect_of(d, s));
      fires[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int d, input string name);
    int n;
    n = 0;
    while (qsize(d) > 0 && n < 20) begin
      applyStimulus(d, 1'b0, 0, 1'b1);
      n++;
    end
    check_int(name, qsize(d), 0);
  endtask

  task automatic checkOutput(input string name, input int d, input logic exp_valid,
                             input logic [W:0] exp_word, input logic exp_ready);
    check({name, "_valid"}, {{W{1'b0}}, ovld[d]}, {{W{1'b0}}, exp_valid});
    check({name, "_word"},  {oerr[d], odata[d]}, exp_word);
    check({name, "_ready"}, {{W{1'b0}}, rdy[d]}, {{W{1'b0}}, exp_ready});
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit, expected summary");
    $fatal(1);
  end

  initial begin
    int p0;
    int f0;
    int ff;
    int fp;
    int n;

    tbl[0] = '{0, 64'h5A00_0000_0000_0000, 1'b0};
    tbl[1] = '{4, 64'h5A00_0000_0000_0004, 1'b0};
    tbl[2] = '{5, 64'h0000_0000_0000_0000, 1'b1};
    tbl[3] = '{7, 64'h0000_0000_0000_0000, 1'b1};
    tbl[4] = '{2, 64'h5A00_0000_0000_0002, 1'b0};
    tbl[5] = '{6, 64'h0000_0000_0000_0000, 1'b1};
    tbl[6] = '{3, 64'h5A00_0000_0000_0003, 1'b0};
    tbl[7] = '{1, 64'h5A00_0000_0000_0001, 1'b0};

    for (int i = 0; i < 32; i++) data0[i*W +: W] = base(0) | W'(i);
    for (int i = 0; i < 5; i++)  data1[i*W +: W] = base(1) | W'(i);
    for (int i = 0; i < 2; i++)  data2[i*W +: W] = base(2) | W'(i);
    for (int i = 0; i < 16; i++) data3[i*W +: W] = base(3) | W'(i);
    for (int d = 0; d < 4; d++) begin
      drive(d, 1'b0, 0, 1'b1);
      fires[d] = 0;
      pops[d] = 0;
      last_pop_cyc[d] = 0;
      held_valid[d] = 1'b0;
      held_data[d] = '0;
      held_err[d] = 1'b0;
      last_data[d] = '0;
      last_err[d] = 1'b0;
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("reset0", 0, 1'b0, '0, 1'b1);
    checkOutput("reset1", 1, 1'b0, '0, 1'b1);

    $display("[TB] N=5 select table");
    for (int i = 0; i < 8; i++) begin
      p0 = pops[1];
      f0 = fires[1];
      applyStimulus(1, 1'b1, tbl[i].sel, 1'b1);
      check_int("tbl_accept", fires[1], f0 + 1);
      n = 0;
      while (pops[1] == p0 && n < 8) begin
        applyStimulus(1, 1'b0, 0, 1'b1);
        n++;
      end
      if (pops[1] == p0) fail("tbl_timeout", "no output", "one output");
      else begin
        check("tbl_word", {last_err[1], last_data[1]}, {tbl[i].exp_err, tbl[i].exp_data});
        check_int("tbl_latency", n, 2);
      end
    end

    $display("[TB] N=32 back-to-back stream");
    p0 = pops[0];
    f0 = fires[0];
    ff = cyc;
    fp = -1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1'b1, i, 1'b1);
      if (fp < 0 && pops[0] > p0) fp = last_pop_cyc[0];
    end
    check_int("stream_accepts", fires[0] - f0, 32);
    n = 0;
    while (pops[0] < p0 + 32 && n < 20) begin
      applyStimulus(0, 1'b0, 0, 1'b1);
      if (fp < 0 && pops[0] > p0) fp = last_pop_cyc[0];
      n++;
    end
    check_int("stream_outputs", pops[0] - p0, 32);
    check_int("stream_latency", fp - ff, 3);
    check_int("stream_no_gap", last_pop_cyc[0] - fp, 31);

    $display("[TB] N=32 fill with out_ready low, then resume");
    f0 = fires[0];
    for (int k = 0; k < 6; k++) applyStimulus(0, 1'b1, k + 3, 1'b0);
    check_int("stall_capacity", fires[0] - f0, 3);
    check_int("stall_in_ready", int'(rdy[0]), 0);
    for (int k = 0; k < 8; k++) begin
      f0 = fires[0];
      p0 = pops[0];
      applyStimulus(0, 1'b1, k + 20, 1'b1);
      check_int("resume_accept", fires[0] - f0, 1);
      check_int("resume_output", pops[0] - p0, 1);
    end
    drain(0, "resume_drain");

    $display("[TB] N=32 single-item bubble");
    f0 = fires[0];
    applyStimulus(0, 1'b1, 7, 1'b0);
    n = 0;
    while (!ovld[0] && n < 8) begin
      applyStimulus(0, 1'b0, 0, 1'b0);
      n++;
    end
    if (!ovld[0]) fail("bubble_timeout", "out_valid=0", "out_valid=1");
    applyStimulus(0, 1'b1, 9, 1'b0);
    check_int("bubble_accept", fires[0] - f0, 2);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1'b0, 0, 1'b0);
    drain(0, "bubble_drain");

    $display("[TB] N=32 reset with items in flight");
    for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, k + 11, 1'b0);
    vld[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset", 0, 1'b0, '0, 1'b1);
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    for (int d = 0; d < 4; d++) held_valid[d] = 1'b0;
    p0 = pops[0];
    for (int k = 0; k < 6; k++) applyStimulus(0, 1'b0, 0, 1'b1);
    check_int("midreset_no_ghost", pops[0] - p0, 0);

    $display("[TB] random handshakes on N=16 and N=2");
    for (int r = 0; r < 2; r++) begin
      int d;
      d = (r == 0) ? 3 : 2;
      f0 = fires[d];
      n = 0;
      while (fires[d] - f0 < 800 && n < 12000) begin
        applyStimulus(d, ($urandom % 2) == 0, int'($urandom % 256), ($urandom % 10) < 3);
        n++;
      end
      check_int("rand_transfers", fires[d] - f0, 800);
      drain(d, "rand_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
